// File: rtl/logicnet_pkg.sv
// Shared widths, FSM states and config-select codes for the LogicNet layer scheduler.
package logicnet_pkg;

  localparam int ACT_W  = 2;
  localparam int FAN_IN = 3;
  localparam int LUT_AW = FAN_IN * ACT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CFG_TABLE = 1'b0;
  localparam logic CFG_INDEX = 1'b1;

endpackage

// File: rtl/logicnet_layer_sched_if.sv
// Vector in/out handshakes plus config port of the layer scheduler.
interface logicnet_layer_sched_if #(
  parameter int NEURONS    = 8,
  parameter int NUM_INPUTS = 16
);
  import logicnet_pkg::*;

  localparam int NW     = $clog2(NEURONS);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int CFG_AW = NW + LUT_AW;
  localparam int CFG_DW = (ACT_W > IDX_W) ? ACT_W : IDX_W;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_INPUTS*ACT_W-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [NEURONS*ACT_W-1:0]    out_data;
  logic                        cfg_we;
  logic                        cfg_sel;
  logic [CFG_AW-1:0]           cfg_addr;
  logic [CFG_DW-1:0]           cfg_data;
  logic                        cfg_err;
  logic                        busy;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err, busy
  );

endinterface

// File: rtl/logicnet_lut_ram.sv
// Shared truth-table store: synchronous write, one-cycle registered read.
// Contents are deliberately not reset so tables survive a layer reset.
module logicnet_lut_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  (* rom_style = "distributed" *) logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/logicnet_layer_sched.sv
// Evaluates one LogicNet layer, one neuron per cycle through a shared LUT RAM.
// out_valid NEURONS+2 cycles after accept; result held until out_ready, no input accepted meanwhile.
module logicnet_layer_sched
  import logicnet_pkg::*;
#(
  parameter int NEURONS    = 8,
  parameter int NUM_INPUTS = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  logicnet_layer_sched_if.slave bus
);

  localparam int NW     = $clog2(NEURONS);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int CFG_AW = NW + LUT_AW;
  localparam int IN_W   = NUM_INPUTS * ACT_W;
  localparam int OUT_W  = NEURONS * ACT_W;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     act_q;
  logic [NW-1:0]       n_q;
  logic                issue_q;
  logic                rd_vld_q;
  logic [NW-1:0]       rd_slot_q;
  logic [OUT_W-1:0]    out_q;
  logic [IDX_W-1:0]    idx_q [NEURONS][FAN_IN];
  logic                cfg_err_q;

  logic                accept;
  logic                last_cap;
  logic                cfg_idle;
  logic [NW-1:0]       cfg_neuron;
  logic [1:0]          cfg_slot;
  logic                idx_bad;
  logic                tbl_we;
  logic                idx_we;
  logic                cfg_err_d;
  logic [LUT_AW-1:0]   lut_addr;
  logic [ACT_W-1:0]    rd_data;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign last_cap = rd_vld_q && (rd_slot_q == NW'(NEURONS - 1));

  // Config decode; writes only land while idle so an evaluation never sees a half-updated table.
  assign cfg_idle   = (state_q == IDLE);
  assign cfg_neuron = bus.cfg_addr[CFG_AW-1 -: NW];
  assign cfg_slot   = bus.cfg_addr[1:0];
  assign idx_bad    = (int'(cfg_slot) >= FAN_IN) || (int'(bus.cfg_data) >= NUM_INPUTS);
  assign tbl_we     = bus.cfg_we && cfg_idle && (bus.cfg_sel == CFG_TABLE);
  assign idx_we     = bus.cfg_we && cfg_idle && (bus.cfg_sel == CFG_INDEX) && !idx_bad;
  assign cfg_err_d  = bus.cfg_we && (!cfg_idle || ((bus.cfg_sel == CFG_INDEX) && idx_bad));

  always_comb begin
    lut_addr = '0;
    for (int j = 0; j < FAN_IN; j++) begin
      lut_addr[j*ACT_W +: ACT_W] = act_q[idx_q[n_q][j]*ACT_W +: ACT_W];
    end
  end

  logicnet_lut_ram #(
    .DEPTH (NEURONS * (1 << LUT_AW)),
    .AW    (CFG_AW),
    .DW    (ACT_W)
  ) u_lut (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data[ACT_W-1:0]),
    .raddr ({n_q, lut_addr}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    if (last_cap) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= '0;
      n_q       <= '0;
      issue_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_slot_q <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int n = 0; n < NEURONS; n++) begin
        for (int j = 0; j < FAN_IN; j++) begin
          idx_q[n][j] <= '0;
        end
      end
    end else begin
      cfg_err_q <= cfg_err_d;
      if (idx_we) begin
        idx_q[cfg_neuron][cfg_slot] <= bus.cfg_data[IDX_W-1:0];
      end
      if (accept) begin
        act_q   <= bus.in_data;
        n_q     <= '0;
        issue_q <= 1'b1;
      end else if (issue_q) begin
        if (n_q == NW'(NEURONS - 1)) begin
          issue_q <= 1'b0;
        end else begin
          n_q <= n_q + 1'b1;
        end
      end
      // Read data returns one cycle after issue; slot tag travels alongside it.
      rd_vld_q  <= issue_q;
      rd_slot_q <= n_q;
      if (rd_vld_q) begin
        out_q[rd_slot_q*ACT_W +: ACT_W] <= rd_data;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logicnet_layer_sched.sv
// Directed bench for logicnet_layer_sched: identity, table pattern, backpressure, config guard, reset, same-cycle config.
module tb_logicnet_layer_sched;
  import logicnet_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   lat;

  logicnet_layer_sched_if #(.NEURONS(8), .NUM_INPUTS(16)) bus ();

  logicnet_layer_sched #(.NEURONS(8), .NUM_INPUTS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cfg_wr(input logic sel, input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = 9'(addr);
    bus.cfg_data = 4'(data);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Presents one vector in IDLE; returns at the negedge of cycle T+1.
  task automatic start(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int from, output int n);
    n = from;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  localparam logic [31:0] IDENT_IN  = 32'hE4E4_E4E4;
  localparam logic [31:0] IDENT_OUT = 32'h0000_E4E4;

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = CFG_TABLE;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity network: every table returns a0, neuron n reads activations n, n+1, n+2.
    for (int n = 0; n < 8; n++) begin
      for (int p = 0; p < 64; p++) cfg_wr(CFG_TABLE, n * 64 + p, p % 4);
      for (int j = 0; j < 3; j++) cfg_wr(CFG_INDEX, n * 64 + j, (n + j) % 16);
    end
    chk("cfg_err_quiet", 32'(bus.cfg_err), 32'd0);

    start(IDENT_IN);
    wait_done(1, lat);
    chk("ident_latency", 32'(lat), 32'd10);
    chk("ident_data", 32'(bus.out_data), IDENT_OUT);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);

    // Backpressure: result must hold while out_ready stays low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), IDENT_OUT);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = IDENT_IN;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_no_b2b", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("reaccept_busy", 32'(bus.busy), 32'd1);
    wait_done(1, lat);
    chk("reaccept_latency", 32'(lat), 32'd10);
    chk("reaccept_data", 32'(bus.out_data), IDENT_OUT);
    drain();

    // Table pattern on neuron 0: only address 6'b000101 yields 2'b11.
    for (int p = 0; p < 64; p++) cfg_wr(CFG_TABLE, p, (p == 5) ? 3 : 0);
    start(32'h0000_0005);
    wait_done(1, lat);
    chk("pat_hit_latency", 32'(lat), 32'd10);
    chk("pat_hit_data", 32'(bus.out_data), 32'h0000_0007);
    drain();
    start(32'h0000_0015);
    wait_done(1, lat);
    chk("pat_miss_data", 32'(bus.out_data), 32'h0000_0014);
    drain();

    // Config guard: write during EVAL is dropped and flagged.
    start(32'h0000_0015);
    cfg_wr(CFG_TABLE, 21, 2);
    chk("guard_err_pulse", 32'(bus.cfg_err), 32'd1);
    @(negedge clk);
    chk("guard_err_clear", 32'(bus.cfg_err), 32'd0);
    wait_done(4, lat);
    chk("guard_done", 32'(bus.out_valid), 32'd1);
    drain();
    start(32'h0000_0015);
    wait_done(1, lat);
    chk("guard_table_kept", 32'(bus.out_data), 32'h0000_0014);
    drain();

    cfg_wr(CFG_INDEX, 3, 5);
    chk("idx_slot3_err", 32'(bus.cfg_err), 32'd1);
    cfg_wr(CFG_INDEX, 0, 0);
    chk("idx_ok_no_err", 32'(bus.cfg_err), 32'd0);

    // Mid-op reset: tables survive, fan-in indices return to zero and are reloaded.
    for (int p = 0; p < 64; p++) cfg_wr(CFG_TABLE, p, p % 4);
    start(IDENT_IN);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_rel_busy", 32'(bus.busy), 32'd0);
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 3; j++) cfg_wr(CFG_INDEX, n * 64 + j, (n + j) % 16);
    end
    start(IDENT_IN);
    wait_done(1, lat);
    chk("mrst_rerun_latency", 32'(lat), 32'd10);
    chk("mrst_rerun_data", 32'(bus.out_data), IDENT_OUT);
    drain();

    // Same-cycle table write and accept: entry {a2=2,a1=1,a0=0} of neuron 0 becomes 3.
    bus.in_valid = 1'b1;
    bus.in_data  = IDENT_IN;
    cfg_wr(CFG_TABLE, 36, 3);
    bus.in_valid = 1'b0;
    wait_done(1, lat);
    chk("same_cyc_latency", 32'(lat), 32'd10);
    chk("same_cyc_data", 32'(bus.out_data), 32'h0000_E4E7);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
